// File: rtl/stack_pkg.sv
// Shared constants, instruction layout and FSM state type for the stack control unit.
package stack_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned OPND_W = 12;
    localparam int unsigned STK_W  = 3;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned MUX_W  = 3;

    localparam logic [STK_W-1:0] STK_NOP     = 3'd0;
    localparam logic [STK_W-1:0] STK_PUSH    = 3'd1;
    localparam logic [STK_W-1:0] STK_POP     = 3'd2;
    localparam logic [STK_W-1:0] STK_REPLACE = 3'd3;

    localparam logic [MUX_W-1:0] MUX_ALU = 3'd0;
    localparam logic [MUX_W-1:0] MUX_IMM = 3'd1;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPC_W-1:0] OP_PUSHI = 4'h1;
    localparam logic [OPC_W-1:0] OP_POP   = 4'h2;
    localparam logic [OPC_W-1:0] OP_ALU   = 4'h3;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'h4;
    localparam logic [OPC_W-1:0] OP_JZ    = 4'h5;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        FETCH_IMM = 2'd1,
        EXEC      = 2'd2,
        HALT      = 2'd3
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [OPND_W-1:0] operand;
    } instr_t;

endpackage

// File: rtl/stack_decoder.sv
// Combinational instruction decode to datapath controls and opcode class flags.
// Branch opcodes are decoded only when STACK_CTRL_BRANCH_EN is defined; otherwise they are illegal.
module stack_decoder
    import stack_pkg::*;
(
    input  instr_t           instr,
    output logic [STK_W-1:0] stack_op,
    output logic [ALU_W-1:0] alu_op,
    output logic [MUX_W-1:0] mux_sel,
    output logic             is_pushi,
    output logic             is_alu,
    output logic             is_jmp,
    output logic             is_jz,
    output logic             is_halt,
    output logic             is_illegal
);

    always_comb begin
        stack_op   = STK_NOP;
        alu_op     = '0;
        mux_sel    = MUX_ALU;
        is_pushi   = 1'b0;
        is_alu     = 1'b0;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (instr.opcode)
            OP_NOP: ;
            OP_PUSHI: begin
                stack_op = STK_PUSH;
                mux_sel  = MUX_IMM;
                is_pushi = 1'b1;
            end
            OP_POP: stack_op = STK_POP;
            OP_ALU: begin
                stack_op = STK_REPLACE;
                alu_op   = instr.operand[ALU_W-1:0];
                mux_sel  = MUX_ALU;
                is_alu   = 1'b1;
            end
`ifdef STACK_CTRL_BRANCH_EN
            OP_JMP: is_jmp = 1'b1;
            OP_JZ: begin
                stack_op = STK_POP;
                is_jz    = 1'b1;
            end
`endif
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/stack_control_unit.sv
// Fetch/execute sequencer for a 16-bit stack machine: pc, ir, immediate and status flags.
// Branch support (JMP/JZ) is selected in stack_decoder by STACK_CTRL_BRANCH_EN.
module stack_control_unit
    import stack_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 12
) (
    input  logic                CLK,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_valid,
    input  logic [WORD_W-1:0]   imem_data,
    input  logic [WORD_W-1:0]   a_in,
    input  logic                ovf_in,
    output logic [STK_W-1:0]    stackOP,
    output logic [ALU_W-1:0]    aluOP,
    output logic [MUX_W-1:0]    mux_selector,
    output logic [WORD_W-1:0]   immediate,
    output logic                halted,
    output logic                illegal,
    output logic                ovf_flag
);

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n;
    instr_t              ir, ir_n;
    logic [WORD_W-1:0]   imm_n;
    logic                req_n, halted_n, illegal_n, ovf_n, fetch_ok, exec_n;
    logic [STK_W-1:0]    stk_n;
    logic [ALU_W-1:0]    alu_n;
    logic [MUX_W-1:0]    mux_n;

    logic [STK_W-1:0]    dec_stack_op;
    logic [ALU_W-1:0]    dec_alu_op;
    logic [MUX_W-1:0]    dec_mux_sel;
    logic                dec_pushi, dec_alu, dec_jmp, dec_jz, dec_halt, dec_illegal;

    assign imem_addr = pc;

    // Decoding ir_n lets the EXEC controls be registered on the same edge that enters EXEC.
    stack_decoder u_decoder (
        .instr      (ir_n),
        .stack_op   (dec_stack_op),
        .alu_op     (dec_alu_op),
        .mux_sel    (dec_mux_sel),
        .is_pushi   (dec_pushi),
        .is_alu     (dec_alu),
        .is_jmp     (dec_jmp),
        .is_jz      (dec_jz),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        imm_n     = immediate;
        illegal_n = illegal;
        ovf_n     = ovf_flag;
        fetch_ok  = imem_req && imem_valid;
        case (state)
            FETCH: begin
                if (fetch_ok) begin
                    ir_n    = instr_t'(imem_data);
                    pc_n    = pc + PC_WIDTH'(1);
                    state_n = dec_pushi ? FETCH_IMM : EXEC;
                end
            end
            FETCH_IMM: begin
                if (fetch_ok) begin
                    imm_n   = imem_data;
                    pc_n    = pc + PC_WIDTH'(1);
                    state_n = EXEC;
                end
            end
            EXEC: begin
                state_n = FETCH;
                if (dec_halt || dec_illegal) state_n = HALT;
                if (dec_illegal) illegal_n = 1'b1;
                if (dec_alu && ovf_in) ovf_n = 1'b1;
                if (dec_jmp || (dec_jz && (a_in == WORD_W'(0)))) pc_n = PC_WIDTH'(ir.operand);
            end
            HALT: ;
            default: state_n = FETCH;
        endcase

        // Datapath controls are live only for the cycle spent in EXEC.
        exec_n   = (state_n == EXEC);
        stk_n    = exec_n ? dec_stack_op : STK_NOP;
        alu_n    = exec_n ? dec_alu_op   : '0;
        mux_n    = exec_n ? dec_mux_sel  : MUX_ALU;
        req_n    = (state_n == FETCH) || (state_n == FETCH_IMM);
        halted_n = (state_n == HALT);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state        <= FETCH;
            pc           <= '0;
            ir           <= '0;
            immediate    <= '0;
            imem_req     <= 1'b0;
            stackOP      <= STK_NOP;
            aluOP        <= '0;
            mux_selector <= MUX_ALU;
            halted       <= 1'b0;
            illegal      <= 1'b0;
            ovf_flag     <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            ir           <= ir_n;
            immediate    <= imm_n;
            imem_req     <= req_n;
            stackOP      <= stk_n;
            aluOP        <= alu_n;
            mux_selector <= mux_n;
            halted       <= halted_n;
            illegal      <= illegal_n;
            ovf_flag     <= ovf_n;
        end
    end

endmodule

// File: tb/tb_stack_control_unit.sv
// Bench for stack_control_unit: ISA-level program model plus directed literal checks.
module tb_stack_control_unit;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] imem_addr;
    logic        imem_req;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic [15:0] a_in = 16'h0;
    logic        ovf_in = 1'b0;
    logic [2:0]  stackOP;
    logic [3:0]  aluOP;
    logic [2:0]  mux_selector;
    logic [15:0] immediate;
    logic        halted, illegal, ovf_flag;

    stack_control_unit #(.PC_WIDTH(12)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_valid   (imem_valid),
        .imem_data    (imem_data),
        .a_in         (a_in),
        .ovf_in       (ovf_in),
        .stackOP      (stackOP),
        .aluOP        (aluOP),
        .mux_selector (mux_selector),
        .immediate    (immediate),
        .halted       (halted),
        .illegal      (illegal),
        .ovf_flag     (ovf_flag)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  stk;
        logic [3:0]  alu;
        logic [2:0]  mux;
        logic [15:0] imm;
    } ev_t;

    logic [15:0] mem [0:4095];
    logic [11:0] fq [$];
    ev_t         eq [$];
    int          chk = 0;
    int          err = 0;
    int          lat = 0;
    int          cnt = 0;
    bit          exp_ill, exp_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk(input logic [2:0] s, input logic [3:0] a, input logic [2:0] m,
                               input logic [15:0] i);
        ev_t e;
        e.stk = s; e.alu = a; e.mux = m; e.imm = i;
        return e;
    endfunction

    // Instruction-level interpretation of the program: fetch address order and EXEC pulses.
    task automatic build_model(input logic [15:0] a, input bit ovf);
        logic [11:0] p;
        logic [15:0] w, im;
        bit          done;
        p = 12'd0; im = 16'd0; done = 1'b0;
        fq.delete(); eq.delete(); exp_ill = 1'b0; exp_ovf = 1'b0;
        for (int s = 0; s < 64 && !done; s++) begin
            w = mem[p];
            fq.push_back(p);
            p = p + 12'd1;
            case (w[15:12])
                4'h0: ;
                4'h1: begin
                    fq.push_back(p);
                    im = mem[p];
                    p = p + 12'd1;
                    eq.push_back(mk(3'd1, 4'd0, 3'd1, im));
                end
                4'h2: eq.push_back(mk(3'd2, 4'd0, 3'd0, im));
                4'h3: begin
                    eq.push_back(mk(3'd3, w[3:0], 3'd0, im));
                    if (ovf) exp_ovf = 1'b1;
                end
`ifdef STACK_CTRL_BRANCH_EN
                4'h4: p = w[11:0];
                4'h5: begin
                    eq.push_back(mk(3'd2, 4'd0, 3'd0, im));
                    if (a == 16'd0) p = w[11:0];
                end
`endif
                4'hF: done = 1'b1;
                default: begin
                    exp_ill = 1'b1;
                    done = 1'b1;
                end
            endcase
        end
    endtask

    // Per-cycle compare against the model, then memory response for the coming edge.
    always @(negedge CLK) begin
        ev_t e, act_ev;
        if (!reset) begin
            imem_valid = 1'b0;
            cnt = 0;
        end else begin
            if (stackOP != 3'd0) begin
                act_ev = mk(stackOP, aluOP, mux_selector, immediate);
                if (eq.size() == 0) begin
                    check("exec_extra", 32'(stackOP), 32'd0);
                end else begin
                    e = eq.pop_front();
                    check("exec_pulse", 32'(act_ev), 32'(e));
                end
                check("req_in_exec", 32'(imem_req), 32'd0);
            end else begin
                check("idle_alu", 32'(aluOP), 32'd0);
                check("idle_mux", 32'(mux_selector), 32'd0);
            end
            if (halted) check("halt_req", 32'(imem_req), 32'd0);
            if (imem_req) begin
                if (cnt >= lat) begin
                    imem_valid = 1'b1;
                    imem_data = mem[imem_addr];
                    if (fq.size() == 0) check("fetch_extra", 32'(imem_req), 32'd0);
                    else check("fetch_addr", 32'(imem_addr), 32'(fq.pop_front()));
                    cnt = 0;
                end else begin
                    imem_valid = 1'b0;
                    cnt++;
                end
            end else begin
                imem_valid = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
    endtask

    task automatic start_prog(input int l, input logic [15:0] a, input bit ovf);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", 32'(imem_addr), 32'd0);
        check("rst_stk", 32'(stackOP), 32'd0);
        check("rst_imm", 32'(immediate), 32'd0);
        check("rst_ovf", 32'(ovf_flag), 32'd0);
        lat = l;
        a_in = a;
        ovf_in = ovf;
        build_model(a, ovf);
        @(negedge CLK);
        reset = 1'b1;
    endtask

    task automatic finish_prog();
        int n = 0;
        while (!halted && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("halt_reached", 32'(halted), 32'd1);
        repeat (4) @(negedge CLK);
        check("halt_sticky", 32'(halted), 32'd1);
        check("illegal", 32'(illegal), 32'(exp_ill));
        check("ovf_flag", 32'(ovf_flag), 32'(exp_ovf));
        check("fetch_left", 32'(fq.size()), 32'd0);
        check("exec_left", 32'(eq.size()), 32'd0);
    endtask

    task automatic wait_stk(input logic [2:0] v);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge CLK);
            if (stackOP == v) ok = 1'b1;
        end
        check("stk_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // PUSHI 0x1234 with zero-latency memory: EXEC on the third edge after release
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h1234; mem[2] = 16'hF000;
        start_prog(0, 16'h0, 1'b0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("pushi_stk", 32'(stackOP), 32'd1);
        check("pushi_mux", 32'(mux_selector), 32'd1);
        check("pushi_imm", 32'(immediate), 32'h1234);
        check("pushi_pc", 32'(imem_addr), 32'd2);
        finish_prog();

        // ALU with overflow: single-cycle REPLACE, sticky ovf_flag
        clear_mem();
        mem[0] = 16'h3005; mem[1] = 16'h0000; mem[2] = 16'h1000; mem[3] = 16'h0042;
        mem[4] = 16'h2000; mem[5] = 16'hF000;
        start_prog(0, 16'h0, 1'b1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("alu_stk", 32'(stackOP), 32'd3);
        check("alu_op", 32'(aluOP), 32'd5);
        @(negedge CLK);
        check("alu_one_cycle", 32'(stackOP), 32'd0);
        finish_prog();
        check("ovf_sticky", 32'(ovf_flag), 32'd1);

        // Same program without overflow
        start_prog(0, 16'h0, 1'b0);
        finish_prog();

        // Mixed program with one-cycle memory latency
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'hBEEF; mem[2] = 16'h0000; mem[3] = 16'h3003;
        mem[4] = 16'h2000; mem[5] = 16'hF000;
        start_prog(1, 16'h0, 1'b0);
        finish_prog();

        // JZ taken / not taken
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h0000; mem[2] = 16'h5040; mem[3] = 16'hF000;
        mem[12'h040] = 16'h1000; mem[12'h041] = 16'h00AA; mem[12'h042] = 16'hF000;
        start_prog(0, 16'h0, 1'b0);
`ifdef STACK_CTRL_BRANCH_EN
        wait_stk(3'd2);
        @(negedge CLK);
        check("jz_taken_pc", 32'(imem_addr), 32'h040);
`endif
        finish_prog();
        start_prog(0, 16'h7, 1'b0);
`ifdef STACK_CTRL_BRANCH_EN
        wait_stk(3'd2);
        @(negedge CLK);
        check("jz_fall_pc", 32'(imem_addr), 32'h003);
`endif
        finish_prog();
`ifndef STACK_CTRL_BRANCH_EN
        check("jz_illegal", 32'(illegal), 32'd1);
`endif

        // Delayed memory: request and address held four cycles, no stack pulse
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h1234; mem[2] = 16'hF000;
        start_prog(3, 16'h0, 1'b0);
        @(posedge CLK);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", 32'(imem_addr), 32'd0);
            check("wait_stk", 32'(stackOP), 32'd0);
        end
        finish_prog();

        // Illegal opcode halts; the next start_prog checks recovery from reset
        clear_mem();
        mem[0] = 16'h8000;
        start_prog(0, 16'h0, 1'b0);
        finish_prog();
        check("ill_flag", 32'(illegal), 32'd1);

        // JMP to the last address, PUSHI whose immediate wraps to 0x000
        clear_mem();
        mem[0] = 16'h4FFF; mem[12'hFFF] = 16'h1000; mem[1] = 16'hF000;
        start_prog(0, 16'h0, 1'b0);
`ifdef STACK_CTRL_BRANCH_EN
        wait_stk(3'd1);
        check("wrap_imm", 32'(immediate), 32'h4FFF);
        check("wrap_pc", 32'(imem_addr), 32'h001);
`endif
        finish_prog();
`ifndef STACK_CTRL_BRANCH_EN
        check("jmp_illegal", 32'(illegal), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
